// File: rtl/cgra_pkg.sv
// Shared definitions for the compute-tile switch byte protocol: header codes,
// tile op codes, byte assembly helpers and the stream driver state encoding.
package cgra_pkg;

    localparam logic [1:0] HDR_WGT = 2'b00;
    localparam logic [1:0] HDR_CFG = 2'b01;
    localparam logic [1:0] HDR_DAT = 2'b10;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_WGT,
        ST_DATA,
        ST_DRAIN
    } drv_state_t;

    function automatic logic [7:0] cfg_byte(input logic [1:0] next_idx, input logic op);
        return {HDR_CFG, next_idx, 3'b000, op};
    endfunction

    function automatic logic [7:0] wgt_byte(input logic [3:0] weight);
        return {HDR_WGT, 2'b00, weight};
    endfunction

    function automatic logic [7:0] dat_byte(input logic [3:0] operand);
        return {HDR_DAT, 2'b00, operand};
    endfunction

endpackage

// File: rtl/tile_stream_driver_if.sv
// Host/tile-facing signal bundle of tile_stream_driver. The driver uses the
// slave modport; the host/loader (and tile model) side uses master.
interface tile_stream_driver_if #(
    parameter int LEN_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [3:0]       cmd_weight;
    logic [1:0]       cmd_next_idx;
    logic [LEN_W-1:0] cmd_len;
    logic             opd_valid;
    logic             opd_ready;
    logic [3:0]       opd_data;
    logic [7:0]       tile_tx;
    logic [7:0]       tile_rx;
    logic             res_valid;
    logic [7:0]       res_data;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_weight, cmd_next_idx, cmd_len,
        output opd_valid, opd_data, tile_rx,
        input  cmd_ready, opd_ready, tile_tx, res_valid, res_data, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_weight, cmd_next_idx, cmd_len,
        input  opd_valid, opd_data, tile_rx,
        output cmd_ready, opd_ready, tile_tx, res_valid, res_data, busy, done
    );
endinterface

// File: rtl/tile_result_pipe.sv
// Tags every DATA byte sent to the tile and captures the tile's result when
// the tag emerges RESULT_LAT cycles later; empty means no result in flight.
module tile_result_pipe #(
    parameter int RESULT_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tag_vld,
    input  logic       tag_last,
    input  logic [7:0] tile_rx,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_last,
    output logic       empty
);
    logic [RESULT_LAT-1:0] vld_p;
    logic [RESULT_LAT-1:0] last_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p     <= '0;
            last_p    <= '0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_data  <= '0;
        end else begin
            vld_p     <= (vld_p << 1) | RESULT_LAT'(tag_vld);
            last_p    <= (last_p << 1) | RESULT_LAT'(tag_vld && tag_last);
            // capture stage: tag leaving the shift register lines up with tile_rx
            res_valid <= vld_p[RESULT_LAT-1];
            res_last  <= vld_p[RESULT_LAT-1] && last_p[RESULT_LAT-1];
            if (vld_p[RESULT_LAT-1]) begin
                res_data <= tile_rx;
            end
        end
    end

    assign empty = (vld_p == '0);

endmodule

// File: rtl/tile_stream_driver.sv
// Serialises one job (CFG, WGT, DATA bytes) onto a compute tile and returns
// its results in order. Define CFG_CACHE_EN to skip CFG/WGT bytes the tile already holds.
module tile_stream_driver
    import cgra_pkg::*;
#(
    parameter int LEN_W      = 4,
    parameter int RESULT_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tile_stream_driver_if.slave  bus
);
    drv_state_t       state;
    logic [LEN_W-1:0] cnt;
    logic             op_r;
    logic [3:0]       wgt_r;
    logic [1:0]       idx_r;
    logic             zero_len_r;
    logic             skip_wgt_r;
    logic [7:0]       last_wgt;
    logic             hit_cfg;
    logic             hit_wgt;
    logic             fire;
    logic             last_fire;
    logic             zlen_done;
    logic             pipe_last;
    logic             pipe_empty;

`ifdef CFG_CACHE_EN
    logic [7:0] cfg_cache;
    logic       cfg_cache_vld;
    logic       wgt_cache_vld;

    // last_wgt doubles as the WGT cache; only the valid bit is separate
    assign hit_cfg = cfg_cache_vld && (cfg_byte(bus.cmd_next_idx, bus.cmd_op) == cfg_cache);
    assign hit_wgt = wgt_cache_vld && (wgt_byte(bus.cmd_weight) == last_wgt);
`else
    assign hit_cfg = 1'b0;
    assign hit_wgt = 1'b0;
`endif

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.opd_ready = (state == ST_DATA) && (cnt != '0);
    assign fire          = bus.opd_valid && bus.opd_ready;
    assign last_fire     = fire && (cnt == LEN_W'(1));
    assign bus.busy      = (state != ST_IDLE) || !pipe_empty;
    assign bus.done      = pipe_last || zlen_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            op_r        <= 1'b0;
            wgt_r       <= '0;
            idx_r       <= '0;
            zero_len_r  <= 1'b0;
            skip_wgt_r  <= 1'b0;
            last_wgt    <= 8'h00;
            bus.tile_tx <= 8'h00;
            zlen_done   <= 1'b0;
`ifdef CFG_CACHE_EN
            cfg_cache     <= 8'h00;
            cfg_cache_vld <= 1'b0;
            wgt_cache_vld <= 1'b0;
`endif
        end else begin
            zlen_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    bus.tile_tx <= last_wgt;
                    if (bus.cmd_valid) begin
                        op_r       <= bus.cmd_op;
                        wgt_r      <= bus.cmd_weight;
                        idx_r      <= bus.cmd_next_idx;
                        cnt        <= bus.cmd_len;
                        zero_len_r <= (bus.cmd_len == '0);
                        skip_wgt_r <= hit_wgt;
                        if (!hit_cfg)                state <= ST_CFG;
                        else if (!hit_wgt)           state <= ST_WGT;
                        else if (bus.cmd_len == '0)  state <= ST_DRAIN;
                        else                         state <= ST_DATA;
                    end
                end
                ST_CFG: begin
                    bus.tile_tx <= cfg_byte(idx_r, op_r);
`ifdef CFG_CACHE_EN
                    cfg_cache     <= cfg_byte(idx_r, op_r);
                    cfg_cache_vld <= 1'b1;
`endif
                    if (!skip_wgt_r)     state <= ST_WGT;
                    else if (zero_len_r) state <= ST_DRAIN;
                    else                 state <= ST_DATA;
                end
                ST_WGT: begin
                    bus.tile_tx <= wgt_byte(wgt_r);
                    last_wgt    <= wgt_byte(wgt_r);
`ifdef CFG_CACHE_EN
                    wgt_cache_vld <= 1'b1;
`endif
                    state <= zero_len_r ? ST_DRAIN : ST_DATA;
                end
                ST_DATA: begin
                    // a cycle without an operand repeats the weight: harmless bubble
                    if (fire) begin
                        bus.tile_tx <= dat_byte(bus.opd_data);
                        cnt         <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) state <= ST_DRAIN;
                    end else begin
                        bus.tile_tx <= last_wgt;
                    end
                end
                ST_DRAIN: begin
                    bus.tile_tx <= last_wgt;
                    if (pipe_empty) begin
                        state     <= ST_IDLE;
                        zlen_done <= zero_len_r;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    tile_result_pipe #(
        .RESULT_LAT (RESULT_LAT)
    ) u_result_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_vld   (fire),
        .tag_last  (last_fire),
        .tile_rx   (bus.tile_rx),
        .res_valid (bus.res_valid),
        .res_data  (bus.res_data),
        .res_last  (pipe_last),
        .empty     (pipe_empty)
    );

endmodule

// File: tb/tb_tile_stream_driver.sv
// Self-checking bench for tile_stream_driver: drives jobs with random operands
// and gaps against a behavioural tile model and a job-level reference model.
module tb_tile_stream_driver;
    import cgra_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tile_stream_driver_if #(.LEN_W(4)) bus();

    tile_stream_driver #(.LEN_W(4), .RESULT_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural tile: registers op/weight from CFG/WGT, one-cycle result for DATA.
    logic       t_op;
    logic [3:0] t_w;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_op        <= 1'b0;
            t_w         <= 4'h0;
            bus.tile_rx <= 8'h00;
        end else begin
            case (bus.tile_tx[7:6])
                2'b01:   t_op <= bus.tile_tx[0];
                2'b00:   t_w  <= bus.tile_tx[3:0];
                2'b10:   bus.tile_rx <= (t_op == OP_SUB) ? (bus.tile_tx - {4'h0, t_w})
                                                         : ({4'h0, t_w} + {4'h0, bus.tile_tx[3:0]});
                default: ;
            endcase
        end
    end

    // Per-cycle log sampled mid-cycle
    logic [7:0] tx_q[$];
    logic [7:0] rd_q[$];
    bit         rv_q[$];
    bit         dn_q[$];
    always @(negedge clk) begin
        if (rst_n) begin
            tx_q.push_back(bus.tile_tx);
            rd_q.push_back(bus.res_data);
            rv_q.push_back(bus.res_valid);
            dn_q.push_back(bus.done);
        end
    end

    // Reference model state: what the tile has been sent since reset
    logic [7:0] m_last_wgt = 8'h00;
    logic [7:0] m_cfg = 8'h00;
    bit         m_cfg_v = 1'b0;
    bit         m_wgt_v = 1'b0;

    logic [3:0] j_opd[16];
    int         j_gap[16];
    bit         j_poke;

    task automatic run_job(input string name, input logic op, input logic [3:0] w,
                           input logic [1:0] idx, input int len);
        logic [7:0] exp_cfg, exp_wgt, got;
        logic [7:0] hdr[$];
        logic [7:0] exp_res[$];
        int dat_idx[$];
        int res_idx[$];
        int acc, t, h, exp_first, ndone, done_idx, bad_idle;
        bit send_cfg, send_wgt;

        exp_cfg  = {2'b01, idx, 3'b000, op};
        exp_wgt  = {4'h0, w};
        send_cfg = 1'b1;
        send_wgt = 1'b1;
`ifdef CFG_CACHE_EN
        if (m_cfg_v && m_cfg == exp_cfg)        send_cfg = 1'b0;
        if (m_wgt_v && m_last_wgt == exp_wgt)   send_wgt = 1'b0;
`endif
        if (send_cfg) hdr.push_back(exp_cfg);
        if (send_wgt) hdr.push_back(exp_wgt);
        h = hdr.size();
        for (int i = 0; i < len; i++)
            exp_res.push_back(op ? ({4'h8, j_opd[i]} - exp_wgt) : (exp_wgt + {4'h0, j_opd[i]}));
        if (send_cfg) begin m_cfg = exp_cfg; m_cfg_v = 1'b1; end
        if (send_wgt) m_wgt_v = 1'b1;
        m_last_wgt = exp_wgt;

        tx_q.delete(); rd_q.delete(); rv_q.delete(); dn_q.delete();
        bus.cmd_op = op; bus.cmd_weight = w; bus.cmd_next_idx = idx; bus.cmd_len = 4'(len);
        bus.cmd_valid = 1'b1;
        t = 0;
        while (!bus.cmd_ready && t < 40) begin @(posedge clk); #1; t++; end
        checks++;
        if (t >= 40) begin errors++; $display("FAIL %s cmd_accept: cmd_ready=%b, required 1", name, bus.cmd_ready); end
        @(posedge clk); #1;
        acc = tx_q.size();
        bus.cmd_valid = 1'b0;

        for (int i = 0; i < len; i++) begin
            bus.opd_valid = 1'b0;
            repeat (j_gap[i]) begin @(posedge clk); #1; end
            if (j_poke) begin bus.cmd_valid = 1'b1; bus.cmd_weight = ~w; bus.cmd_len = 4'd7; end
            bus.opd_valid = 1'b1;
            bus.opd_data  = j_opd[i];
            t = 0;
            while (!bus.opd_ready && t < 40) begin @(posedge clk); #1; t++; end
            if (t >= 40) begin
                checks++; errors++;
                $display("FAIL %s opd_accept[%0d]: opd_ready=%b, required 1", name, i, bus.opd_ready);
            end
            @(posedge clk); #1;
        end
        bus.opd_valid = 1'b0;
        bus.cmd_valid = 1'b0;

        t = 0;
        while (!(bus.cmd_ready && !bus.busy) && t < 60) begin @(posedge clk); #1; t++; end
        checks++;
        if (t >= 60) begin errors++; $display("FAIL %s drain: busy=%b cmd_ready=%b, required 0/1", name, bus.busy, bus.cmd_ready); end
        repeat (2) begin @(posedge clk); #1; end

        for (int k = 0; k < h; k++) begin
            got = (acc + 1 + k < tx_q.size()) ? tx_q[acc + 1 + k] : 8'hxx;
            checks++;
            if (got !== hdr[k]) begin errors++; $display("FAIL %s hdr[%0d]: tile_tx=%h, required %h", name, k, got, hdr[k]); end
        end

        bad_idle = 0; ndone = 0; done_idx = -1;
        for (int j = acc + 1 + h; j < tx_q.size(); j++) begin
            if (tx_q[j][7:6] == 2'b10) dat_idx.push_back(j);
            else if (tx_q[j] !== exp_wgt) bad_idle++;
        end
        for (int j = acc; j < rv_q.size(); j++) begin
            if (rv_q[j]) res_idx.push_back(j);
            if (dn_q[j]) begin ndone++; done_idx = j; end
        end
        checks++;
        if (bad_idle != 0) begin errors++; $display("FAIL %s idle_bytes: %0d non-weight idle bytes, required 0", name, bad_idle); end

        checks++;
        if (dat_idx.size() != len) begin errors++; $display("FAIL %s data_count: %0d, required %0d", name, dat_idx.size(), len); end
        for (int i = 0; i < len && i < dat_idx.size(); i++) begin
            checks++;
            if (tx_q[dat_idx[i]] !== {4'h8, j_opd[i]}) begin
                errors++; $display("FAIL %s data[%0d]: tile_tx=%h, required %h", name, i, tx_q[dat_idx[i]], {4'h8, j_opd[i]});
            end
        end
        if (len > 0 && dat_idx.size() > 0) begin
            exp_first = acc + 1 + ((h > j_gap[0]) ? h : j_gap[0]);
            checks++;
            if (dat_idx[0] != exp_first) begin
                errors++; $display("FAIL %s first_data_cycle: %0d, required %0d", name, dat_idx[0] - acc, exp_first - acc);
            end
        end

        checks++;
        if (res_idx.size() != len) begin errors++; $display("FAIL %s res_count: %0d, required %0d", name, res_idx.size(), len); end
        for (int i = 0; i < len && i < res_idx.size(); i++) begin
            checks++;
            if (rd_q[res_idx[i]] !== exp_res[i]) begin
                errors++; $display("FAIL %s res_data[%0d]: %h, required %h", name, i, rd_q[res_idx[i]], exp_res[i]);
            end
            if (i < dat_idx.size()) begin
                checks++;
                if (res_idx[i] != dat_idx[i] + 2) begin
                    errors++; $display("FAIL %s res_latency[%0d]: %0d, required 2", name, i, res_idx[i] - dat_idx[i]);
                end
            end
        end

        checks++;
        if (ndone != 1) begin errors++; $display("FAIL %s done_count: %0d, required 1", name, ndone); end
        if (len > 0 && res_idx.size() > 0) begin
            checks++;
            if (done_idx != res_idx[res_idx.size() - 1]) begin
                errors++; $display("FAIL %s done_align: done at %0d, required %0d", name, done_idx, res_idx[res_idx.size() - 1]);
            end
        end else if (len == 0) begin
            checks++;
            if (done_idx <= acc + h) begin errors++; $display("FAIL %s done_zero_len: done at %0d, required > %0d", name, done_idx - acc, h); end
        end
    endtask

    task automatic set_job(input int len, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            j_opd[i] = 4'($urandom);
            j_gap[i] = (gaps && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
        end
        j_poke = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.tile_tx !== 8'h00) begin errors++; $display("FAIL reset tile_tx: %h, required 00", bus.tile_tx); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset res_valid: %b, required 0", bus.res_valid); end
        checks++; if (bus.res_data !== 8'h00) begin errors++; $display("FAIL reset res_data: %h, required 00", bus.res_data); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done: %b, required 0", bus.done); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset cmd_ready: %b, required 1", bus.cmd_ready); end
        checks++; if (bus.opd_ready !== 1'b0) begin errors++; $display("FAIL reset opd_ready: %b, required 0", bus.opd_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: %b, required 0", bus.busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (bus.tile_tx !== 8'h00) begin errors++; $display("FAIL reset idle_tx: %h, required 00", bus.tile_tx); end
    endtask

    task automatic test_add();
        set_job(2, 1'b0);
        j_opd[0] = 4'd5; j_opd[1] = 4'd7;
        run_job("add", 1'b0, 4'd3, 2'd2, 2);
    endtask

    task automatic test_sub();
        set_job(1, 1'b0);
        j_opd[0] = 4'd4;
        run_job("sub", 1'b1, 4'd2, 2'd0, 1);
    endtask

    task automatic test_zero_len();
        set_job(0, 1'b0);
        run_job("zero_len", 1'($urandom), 4'd9, 2'($urandom), 0);
    endtask

    task automatic test_stall();
        set_job(3, 1'b0);
        j_gap[1] = 2; j_gap[2] = 2;
        j_poke = 1'b1;
        run_job("stall", 1'b0, 4'd6, 2'd1, 3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            set_job(0, 1'b1);
            run_job("random", 1'($urandom), 4'($urandom), 2'($urandom), int'($urandom_range(0, 6)));
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a, b;
        set_job(2, 1'b0);
        a = j_opd[0]; b = j_opd[1];
        run_job("b2b_first", 1'b1, 4'd11, 2'd3, 2);
        set_job(2, 1'b0);
        j_opd[0] = b; j_opd[1] = a;
        run_job("b2b_second", 1'b1, 4'd11, 2'd3, 2);
    endtask

    task automatic test_reset_mid_job();
        int t, bad;
        bus.cmd_op = 1'b0; bus.cmd_weight = 4'd5; bus.cmd_next_idx = 2'd1; bus.cmd_len = 4'd3;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.opd_valid = 1'b1; bus.opd_data = 4'd9;
        t = 0;
        while (!bus.opd_ready && t < 40) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        bus.opd_valid = 1'b0;
        checks++;
        if (bus.tile_tx !== 8'h89) begin errors++; $display("FAIL rst_mid data_sent: tile_tx=%h, required 89", bus.tile_tx); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.tile_tx !== 8'h00) begin errors++; $display("FAIL rst_mid tile_tx: %h, required 00", bus.tile_tx); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_mid res_valid: %b, required 0", bus.res_valid); end
        m_cfg_v = 1'b0; m_wgt_v = 1'b0; m_last_wgt = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.res_valid || bus.done) bad++;
        end
        @(posedge clk); #1;
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid spurious: %0d res/done cycles, required 0", bad); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid cmd_ready: %b, required 1", bus.cmd_ready); end
        checks++; if (bus.tile_tx !== 8'h00) begin errors++; $display("FAIL rst_mid idle_tx: %h, required 00", bus.tile_tx); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_weight = 4'h0;
        bus.cmd_next_idx = 2'd0; bus.cmd_len = 4'd0;
        bus.opd_valid = 1'b0; bus.opd_data = 4'h0;
        j_poke = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_add();
        test_sub();
        test_zero_len();
        test_stall();
        test_random();
        test_back_to_back();
        test_reset_mid_job();
        test_add();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tile_stream_driver.md
Name: tile_stream_driver

Overview:
- Transmit end of the compute-tile switch byte protocol: accepts one job command plus a stream of 4-bit operands.
- Serialises each job onto the tile's switch input as a CFG byte, then a WGT byte, then one DATA byte per operand.
- Captures the tile's registered result bytes and returns them in order with a valid strobe.
- Sits between the host/loader fabric and one compute tile; one instance per tile.

Parameters:
- LEN_W, 4, width of cmd_len (max burst = 2^LEN_W-1 operands).
- RESULT_LAT, 2, cycles from a DATA byte appearing on tile_tx to its result being sampled into res_data (1 tile register + 1 capture register).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  job command valid
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  tile op: 0 add, 1 subtract
- cmd_weight  in  4  weight for the job
- cmd_next_idx  in  2  next-core index for the CFG byte
- cmd_len  in  LEN_W  operand count; 0 is legal
- opd_valid  in  1  operand valid
- opd_ready  out  1  high in DATA state while operands remain
- opd_data  in  4  operand
- tile_tx  out  8  registered byte to the tile switch input
- tile_rx  in  8  tile switch output (result)
- res_valid  out  1  result strobe, one cycle per operand
- res_data  out  8  captured result byte
- busy  out  1  high whenever state != IDLE or results are in flight
- done  out  1  one-cycle pulse with the job's final result (or at DRAIN exit when cmd_len=0)

Behaviour:
- Byte encodings (tile_tx):
  - CFG = {2'b01, next_idx, 3'b000, op}
  - WGT = {2'b00, 2'b00, weight}
  - DATA = {2'b10, 2'b00, operand}
- Idle byte: tile_tx holds last_wgt, the last WGT byte sent; it is idempotent on the tile.
- Reset values: tile_tx=8'h00 (WGT 0, matching tile reset weight); last_wgt=8'h00; res_valid=0; res_data=0; done=0; state=IDLE; remaining count 0; result pipe cleared.
- FSM IDLE -> CFG -> WGT -> DATA -> DRAIN -> IDLE:
  - IDLE: cmd_ready=1. On cmd_valid, latch op/weight/idx/len; next cycle tile_tx=CFG.
  - CFG: one cycle. Next state WGT, which drives the WGT byte and updates last_wgt.
  - WGT: if latched len=0 go to DRAIN, else DATA.
  - DATA: each cycle with opd_valid&&opd_ready, tile_tx=DATA byte and decrement count. A cycle without opd_valid drives last_wgt (bubble, no result expected). After the count hits 0, go to DRAIN.
  - DRAIN: wait until the result pipe is empty, then return to IDLE.
- Result path:
  - A valid-flag shift register of depth RESULT_LAT tags every DATA byte.
  - When a tag exits, res_data<=tile_rx and res_valid=1. Results are strictly in operand order.
  - done asserts in the same cycle as the final res_valid.
  - For len=0, done pulses on the cycle DRAIN exits.
- Cycle timing: cmd accepted at edge 0 -> CFG on tile_tx in cycle 1, WGT in cycle 2, first DATA in cycle 3 at the earliest, first res_valid in cycle 5.
- No backpressure on results; the consumer must always accept.
- cmd_valid outside IDLE is ignored (cmd_ready=0). opd_valid outside DATA is ignored.
- Reset mid-job: returns immediately to reset values; in-flight results are discarded; no done pulse.

Optional Feature:
- Macro CFG_CACHE_EN.
- When defined:
  - Hold a cache of the last CFG byte and last WGT byte, each with a valid bit cleared on reset.
  - CFG state is skipped when the new CFG byte equals the cached one; WGT is skipped likewise.
  - If both match, the first DATA byte can appear in cycle 1.
- When undefined: CFG and WGT are always sent, exactly as above.

Decomposition:
- Shared package cgra_pkg:
  - header constants HDR_WGT=2'b00, HDR_CFG=2'b01, HDR_DAT=2'b10
  - byte-assembly functions for CFG/WGT/DATA
  - state encoding for IDLE/CFG/WGT/DATA/DRAIN
  - tile op constants OP_ADD/OP_SUB
- Sub-module tile_result_pipe: RESULT_LAT-deep tag shift register plus capture register, producing res_valid/res_data and an empty flag.

Test Plan:
- op=0, w=3, idx=2, len=2, operands 5,7 -> tile_tx sequence 0x60, 0x03, 0x85, 0x87, then 0x03 idle; res_data 0x08, 0x0A; done with the second result.
- op=1, w=2, idx=0, len=1, operand 4 -> tile_tx 0x41, 0x02, 0x84; res_data 0x82 (tile subtracts from the full byte); done=1.
- len=0, w=9 -> tile_tx 0x4x, 0x09; no res_valid; done pulses on DRAIN exit; cmd_ready high again afterwards.
- Operand stall: len=3, opd_valid low for 2 cycles between operands -> tile_tx=last_wgt during the gap; exactly 3 res_valid in order; no spurious result.
- Reset asserted during DATA after 1 of 3 operands -> tile_tx=0x00, res_valid=0, no done, cmd_ready=1 after release.
- CFG_CACHE_EN: two identical jobs back-to-back -> the second job emits no CFG/WGT bytes and its first DATA appears the cycle after acceptance.
